// File: rtl/neuron_layer.sv
// neuron_layer: M parallel fixed-point neurons sharing one streamed input
// vector of N elements. Each neuron accumulates x*w_j over N consecutive
// cycles, adds its bias, rescales by FRAC bits and saturates to W bits. It
// then applies ReLU or identity and publishes the result with a done pulse.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (aborts any operation, clears y)
//   start    begin an operation; only honoured while idle
//   x        signed input element, shared by all neurons (element 0 on start)
//   w        packed signed weights, neuron j uses w[j*W +: W]
//   b        packed signed biases (same Q format as x), latched on start
//   relu_en  1 = ReLU, 0 = identity; latched on start
//   busy     high while an operation is in flight
//   done     one-cycle pulse in the cycle y is updated
//   y        packed signed results, neuron j is y[j*W +: W]
module neuron_layer #(
    parameter int N    = 4,
    parameter int M    = 4,
    parameter int W    = 16,
    parameter int FRAC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic signed [W-1:0] x,
    input  logic [M*W-1:0]      w,
    input  logic [M*W-1:0]      b,
    input  logic                relu_en,
    output logic                busy,
    output logic                done,
    output logic [M*W-1:0]      y
);

    // Worst case |sum| is N * 2^(2W-2); this width holds it with room to spare.
    localparam int ACC_W = 2*W + $clog2(N) + 1;
    // One extra bit so adding the shifted bias can never wrap.
    localparam int T_W   = ACC_W + 1;
    localparam int CNT_W = $clog2(N + 1);

    localparam logic signed [T_W-1:0] LIM_MAX = {{(T_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [T_W-1:0] LIM_MIN = {{(T_W-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_ACT
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc [M];
    logic [M*W-1:0]           r_b;
    logic                     r_relu;
    logic [M*W-1:0]           r_y;
    logic                     r_done;

    logic signed [ACC_W-1:0]  w_prod_ext [M];
    logic [M*W-1:0]           w_y_next;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples values from before the edge.
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: the default assignment first covers every path, so no latch
        // is inferred when a case branch leaves the state unchanged.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = (N == 1) ? S_ACT : S_ACC;
            S_ACC:   if (r_cnt == CNT_W'(N - 1)) w_state_next = S_ACT;
            S_ACT:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Per-neuron product and activation datapath.
    for (genvar j = 0; j < M; j++) begin : g_neuron
        logic signed [W-1:0]   w_wj;
        logic signed [W-1:0]   w_bj;
        logic signed [2*W-1:0] w_prod;
        logic signed [T_W-1:0] w_bias_ext;
        logic signed [T_W-1:0] w_t;
        logic signed [T_W-1:0] w_s;
        logic signed [W-1:0]   w_sat;

        assign w_wj   = w[j*W +: W];
        assign w_bj   = r_b[j*W +: W];
        assign w_prod = x * w_wj;
        assign w_prod_ext[j] = {{(ACC_W-2*W){w_prod[2*W-1]}}, w_prod};

        // Bias is in the same Q format as x, so align it to the product's
        // 2*FRAC fractional bits before adding.
        assign w_bias_ext = {{(T_W-W){w_bj[W-1]}}, w_bj} <<< FRAC;
        assign w_t        = {r_acc[j][ACC_W-1], r_acc[j]} + w_bias_ext;
        // Arithmetic shift rounds toward minus infinity.
        assign w_s        = w_t >>> FRAC;
        assign w_sat      = (w_s > LIM_MAX) ? LIM_MAX[W-1:0] :
                            (w_s < LIM_MIN) ? LIM_MIN[W-1:0] : w_s[W-1:0];
        assign w_y_next[j*W +: W] = (r_relu && w_sat[W-1]) ? '0 : w_sat;
    end

    // Accumulators, operand latches and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_b    <= '0;
            r_relu <= 1'b0;
            r_y    <= '0;
            r_done <= 1'b0;
            // NOTE: the accumulator array is small register storage, not a
            // RAM, so clearing it in reset is cheap and keeps state defined.
            for (int j = 0; j < M; j++) r_acc[j] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // Clear-and-add: element 0 is loaded directly.
                        for (int j = 0; j < M; j++) r_acc[j] <= w_prod_ext[j];
                        r_cnt  <= CNT_W'(1);
                        r_b    <= b;
                        r_relu <= relu_en;
                    end
                end
                S_ACC: begin
                    for (int j = 0; j < M; j++) r_acc[j] <= r_acc[j] + w_prod_ext[j];
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_ACT: begin
                    r_y    <= w_y_next;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign y    = r_y;

endmodule

// File: tb/tb_neuron_layer.sv
// tb_neuron_layer: directed checks of neuron_layer in its main configuration
// (N=4, M=2, W=16, FRAC=8). It also exercises two corner configurations
// (N=1/M=8/FRAC=0 and N=7/M=1/FRAC=8) against a small reference model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_neuron_layer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Main instance: N=4, M=2, W=16, FRAC=8.
    logic               m_start = 1'b0;
    logic signed [15:0] m_x     = '0;
    logic [31:0]        m_w     = '0;
    logic [31:0]        m_b     = '0;
    logic               m_relu  = 1'b0;
    logic               m_busy;
    logic               m_done;
    logic [31:0]        m_y;

    neuron_layer #(.N(4), .M(2), .W(16), .FRAC(8)) u_main (
        .clk(clk), .rst(rst), .start(m_start), .x(m_x), .w(m_w), .b(m_b),
        .relu_en(m_relu), .busy(m_busy), .done(m_done), .y(m_y)
    );

    // Corner instance: N=1, M=8, FRAC=0.
    logic               s1_start = 1'b0;
    logic signed [15:0] s1_x     = '0;
    logic [127:0]       s1_w     = '0;
    logic [127:0]       s1_b     = '0;
    logic               s1_relu  = 1'b0;
    logic               s1_busy;
    logic               s1_done;
    logic [127:0]       s1_y;

    neuron_layer #(.N(1), .M(8), .W(16), .FRAC(0)) u_s1 (
        .clk(clk), .rst(rst), .start(s1_start), .x(s1_x), .w(s1_w), .b(s1_b),
        .relu_en(s1_relu), .busy(s1_busy), .done(s1_done), .y(s1_y)
    );

    // Corner instance: N=7, M=1, FRAC=8.
    logic               s7_start = 1'b0;
    logic signed [15:0] s7_x     = '0;
    logic [15:0]        s7_w     = '0;
    logic [15:0]        s7_b     = '0;
    logic               s7_relu  = 1'b0;
    logic               s7_busy;
    logic               s7_done;
    logic [15:0]        s7_y;

    neuron_layer #(.N(7), .M(1), .W(16), .FRAC(8)) u_s7 (
        .clk(clk), .rst(rst), .start(s7_start), .x(s7_x), .w(s7_w), .b(s7_b),
        .relu_en(s7_relu), .busy(s7_busy), .done(s7_done), .y(s7_y)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: floor((acc + bias*2^frac) / 2^frac), clamp to 16 bits, ReLU.
    function automatic longint model(input longint acc, input longint bias,
                                     input int frac, input bit relu);
        longint t;
        t = (acc + (bias <<< frac)) >>> frac;
        if (t > 32767)       t = 32767;
        else if (t < -32768) t = -32768;
        if (relu && t < 0)   t = 0;
        return t;
    endfunction

    // Random operand: full range half the time, small magnitude otherwise.
    function automatic logic signed [15:0] rnd();
        logic signed [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 1) == 1) r = r >>> 6;
        return r;
    endfunction

    // One operation on the main instance. Called at a falling edge (cycle 0)
    // and returns at the falling edge of the done cycle, so another call may
    // follow immediately as a back-to-back start. b and relu_en are scrambled
    // after cycle 0 to confirm they are latched; x is scrambled during ACT.
    task automatic main_op(input string tag, input logic [3:0][15:0] xs,
                           input logic signed [15:0] w0, input logic signed [15:0] w1,
                           input logic signed [15:0] b0, input logic signed [15:0] b1,
                           input bit relu, input bit mid_start,
                           input longint e0, input longint e1);
        logic [5:0]         busy_seen;
        logic [5:0]         done_seen;
        logic signed [15:0] yv;
        busy_seen = '0;
        done_seen = '0;
        m_start = 1'b1;
        m_x     = xs[0];
        m_w     = {w1, w0};
        m_b     = {b1, b0};
        m_relu  = relu;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            busy_seen[c] = m_busy;
            done_seen[c] = m_done;
            m_start = (mid_start && c == 2);
            m_x     = (c < 4) ? xs[c] : 16'sh5a5a;
            m_b     = 32'h7f00_8100;
            m_relu  = ~relu;
        end
        m_start = 1'b0;
        check({tag, " busy c1..5"}, busy_seen[5:1], 5'b01111);
        check({tag, " done c1..5"}, done_seen[5:1], 5'b10000);
        yv = m_y[15:0];
        check({tag, " y0"}, yv, e0);
        yv = m_y[31:16];
        check({tag, " y1"}, yv, e1);
    endtask

    task automatic sweep_s1(input int trial);
        longint             xv;
        longint             wv [8];
        longint             bv [8];
        bit                 rl;
        int                 got_cyc;
        logic [127:0]       cap;
        logic signed [15:0] r;
        r  = rnd(); xv = r; s1_x = r;
        for (int j = 0; j < 8; j++) begin
            r = rnd(); wv[j] = r; s1_w[j*16 +: 16] = r;
            r = rnd(); bv[j] = r; s1_b[j*16 +: 16] = r;
        end
        rl       = 1'($urandom_range(0, 1));
        s1_relu  = rl;
        s1_start = 1'b1;
        got_cyc  = -1;
        cap      = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            s1_start = 1'b0;
            if (s1_done) begin
                got_cyc = c;
                cap     = s1_y;
                break;
            end
        end
        check($sformatf("n1 t%0d latency", trial), got_cyc, 2);
        for (int j = 0; j < 8; j++) begin
            r = cap[j*16 +: 16];
            check($sformatf("n1 t%0d y%0d", trial, j), r, model(xv * wv[j], bv[j], 0, rl));
        end
    endtask

    task automatic sweep_s7(input int trial);
        longint             xv [7];
        longint             wv;
        longint             bv;
        longint             acc;
        bit                 rl;
        int                 got_cyc;
        logic [15:0]        cap;
        logic signed [15:0] r;
        for (int k = 0; k < 7; k++) begin
            r = rnd(); xv[k] = r;
        end
        r = rnd(); wv = r; s7_w = r;
        r = rnd(); bv = r; s7_b = r;
        acc = 0;
        for (int k = 0; k < 7; k++) acc += xv[k] * wv;
        rl       = 1'($urandom_range(0, 1));
        s7_relu  = rl;
        s7_x     = 16'(xv[0]);
        s7_start = 1'b1;
        got_cyc  = -1;
        cap      = '0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            s7_start = 1'b0;
            s7_x     = (c < 7) ? 16'(xv[c]) : 16'sh1234;
            if (s7_done) begin
                got_cyc = c;
                cap     = s7_y;
                break;
            end
        end
        check($sformatf("n7 t%0d latency", trial), got_cyc, 8);
        r = cap;
        check($sformatf("n7 t%0d y", trial), r, model(acc, bv, 8, rl));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][15:0] xs;
        logic             seen;

        repeat (3) @(negedge clk);
        check("reset busy", m_busy, 0);
        check("reset done", m_done, 0);
        check("reset y", m_y, 0);
        check("reset y n1", s1_y, 0);
        check("reset y n7", s7_y, 0);
        rst = 1'b0;
        @(negedge clk);

        xs = {16'sd256, 16'sd256, 16'sd256, 16'sd256};
        main_op("basic", xs, 16'sd128, -16'sd256, 16'sd256, 16'sd0, 1'b0, 1'b0, 768, -1024);
        main_op("relu", xs, 16'sd128, -16'sd256, 16'sd256, 16'sd0, 1'b1, 1'b0, 768, 0);

        xs = {16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767};
        main_op("sat", xs, 16'sd32767, -16'sd32768, 16'sd0, 16'sd0, 1'b0, 1'b0, 32767, -32768);

        xs = {16'sd0, 16'sd0, 16'sd0, 16'sd1};
        main_op("round", xs, 16'sd1, -16'sd1, 16'sd0, 16'sd0, 1'b0, 1'b0, 0, -1);

        // Back-to-back pair; the second one also sees an ignored mid-op start.
        xs = {16'sd256, 16'sd256, 16'sd256, 16'sd256};
        main_op("b2b first", xs, 16'sd128, -16'sd256, 16'sd256, 16'sd0, 1'b0, 1'b0, 768, -1024);
        xs = {16'sd128, -16'sd256, 16'sd512, 16'sd256};
        main_op("b2b second", xs, 16'sd256, 16'sd64, -16'sd256, 16'sd512, 1'b0, 1'b1, 384, 672);

        // Reset asserted in cycle 2 of an operation.
        m_start = 1'b1;
        m_x     = 16'sd256;
        m_w     = {-16'sd256, 16'sd128};
        m_b     = {16'sd0, 16'sd256};
        m_relu  = 1'b0;
        @(negedge clk);
        m_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst-mid busy", m_busy, 0);
        check("rst-mid done", m_done, 0);
        check("rst-mid y", m_y, 0);
        rst  = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= m_done;
        end
        check("rst-mid no done", seen, 0);

        xs = {16'sd256, 16'sd256, 16'sd256, 16'sd256};
        main_op("after rst", xs, 16'sd128, -16'sd256, 16'sd256, 16'sd0, 1'b1, 1'b0, 768, 0);
        @(negedge clk);
        check("done single pulse", m_done, 0);
        check("idle busy", m_busy, 0);

        for (int t = 0; t < 4; t++) sweep_s1(t);
        for (int t = 0; t < 4; t++) sweep_s7(t);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
